fetch_unit: RTL
===============

# fetch_unit

Parametrised instruction-fetch front end for the processor, replacing the fixed PC register and PC+4 adder. It owns the program counter, issues pipelined requests to an instruction memory with a request/grant/response handshake, and buffers returned instructions with their PCs in an in-order queue of configurable depth. A redirect input (taken branch/jump) flushes the queue, discards in-flight responses and restarts fetch at a new address.

## Interface
- XLEN, 32: address and PC width.
- DEPTH, 4: instruction queue entries; power of two, minimum 2.
- RESET_VECTOR, 0: first fetch address after reset; bits [1:0] must be 0.

- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address, word-aligned.
- imem_gnt  in  1  memory accepts request this cycle (imem_req & imem_gnt = issue).
- imem_rvalid  in  1  response valid; responses return in issue order, at least 1 cycle after issue.
- imem_rdata  in  32  instruction word for oldest outstanding request.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  XLEN  restart address; bits [1:0] ignored, treated as 0.
- instr_valid  out  1  queue head valid.
- instr  out  32  queue head instruction.
- instr_pc  out  XLEN  address instr was fetched from.
- instr_ready  in  1  consumer takes head (instr_valid & instr_ready = pop).

## Operation
- State: fetch_pc (XLEN), queue of DEPTH {instr, pc} entries with count, outstanding counter (requests issued, response not yet received), drop counter (outstanding responses to discard), pc FIFO tracking addresses of outstanding requests.
- imem_req = (count + outstanding < DEPTH) & ~redirect; imem_addr = fetch_pc. Once asserted, imem_addr holds until granted or redirected.
- Issue: fetch_pc <= fetch_pc + 4, modulo 2^XLEN (wraps 0xFFFFFFFC -> 0x0). outstanding increments.
- Response: outstanding decrements. If drop > 0, drop decrements and data is discarded; else {imem_rdata, pc} pushed to queue. Credit rule guarantees queue never overflows; a response arriving with full queue is impossible by construction (assertion in bench).
- Pop: head advances, count decrements. Push and pop in same cycle leave count unchanged.
- Redirect (highest priority): queue count <= 0; fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}; drop <= outstanding after this cycle's issue/response accounting (a response arriving this cycle is discarded, not pushed); instr_valid forced 0 this cycle, pop ignored. No request issued in the redirect cycle.
- Back-to-back redirects: last one wins; drop accumulates correctly.
- Memory must be reset together with this block; responses after reset are treated as fresh.

## Timing
- Reset values: imem_req 0 while reset low, imem_addr RESET_VECTOR, instr_valid 0, instr 0, instr_pc 0, all counters 0.
- First cycle after reset release: imem_req 1, imem_addr RESET_VECTOR.
- Queue is registered: instruction returned in cycle n is on instr/instr_valid in cycle n+1. With 1-cycle memory, issue to instr_valid = 2 cycles.
- Throughput: one instruction per cycle with 1-cycle memory and DEPTH >= 3; DEPTH = 2 sustains one per two cycles.
- Redirect in cycle n: imem_req 1 with redirect_pc in cycle n+1; first redirected instruction earliest at n+3 with 1-cycle memory.
- Consumer stall (instr_ready 0): requests stop once count + outstanding = DEPTH; resume the cycle after a pop frees a slot.

## Test plan
- Reset release, RESET_VECTOR=0x100, gnt always 1, 1-cycle memory returning addr-derived data -> instr_pc 0x100,0x104,0x108,... on consecutive cycles from cycle 2, instr matches.
- instr_ready held 0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, imem_req then 0, instr_valid 1 holding 0x100; release -> in-order drain, no loss or duplicate.
- Redirect to 0x2003 with 2 requests outstanding -> next imem_addr 0x2000, the 2 stale responses dropped, first instr_pc out 0x2000.
- Redirect coinciding with imem_rvalid and imem_gnt in same cycle -> both responses discarded, no stale instr_pc appears.
- fetch_pc near 0xFFFFFFF8, XLEN=32 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
- reset asserted mid-stream with queue full -> outputs return to reset values asynchronously, refetch from RESET_VECTOR after release.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
// This block owns the program counter and issues pipelined requests to the
// instruction memory. It buffers returned words together with their PCs in an
// in-order queue. A redirect empties the queue, marks in-flight responses to be
// discarded, and restarts fetch at the new address.
module fetch_unit #(
  parameter int              XLEN         = 32,
  parameter int              DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] fetchPc_q, fetchPc_d;
  logic [CW-1:0]   qCount_q, qCount_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [31:0]     qInstr_q [DEPTH];
  logic [XLEN-1:0] qPc_q    [DEPTH];
  logic [PW-1:0]   qHead_q, qTail_q;

  logic [XLEN-1:0] pcFifo_q [DEPTH];
  logic [PW-1:0]   pfHead_q, pfTail_q;

  logic            credit;
  logic            issue;
  logic            resp;
  logic            dropResp;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] respPc;
  logic [1:0]      unusedPcBits;

  // The low redirect address bits are forced to zero, so they are never read.
  assign unusedPcBits = redirect_pc[1:0];

  // A request may only go out when the queue has room for every request in flight.
  assign credit = ({1'b0, qCount_q} + {1'b0, outstanding_q}) < (CW+1)'(DEPTH);

  assign imem_req    = credit & ~redirect & reset;
  assign imem_addr   = fetchPc_q;
  assign issue       = imem_req & imem_gnt;
  assign resp        = imem_rvalid & (outstanding_q != '0);
  assign dropResp    = resp & (drop_q != '0);
  assign push        = resp & ~dropResp & ~redirect;
  assign respPc      = pcFifo_q[pfHead_q];

  assign instr_valid = (qCount_q != '0) & ~redirect;
  assign instr       = qInstr_q[qHead_q];
  assign instr_pc    = qPc_q[qHead_q];
  assign pop         = instr_valid & instr_ready;

  // Next-state accounting for the PC, queue occupancy, in-flight and drop counters.
  always_comb begin
    fetchPc_d     = fetchPc_q;
    qCount_d      = qCount_q + CW'(push) - CW'(pop);
    outstanding_d = outstanding_q + CW'(issue) - CW'(resp);
    drop_d        = drop_q;
    if (issue) begin
      fetchPc_d = fetchPc_q + XLEN'(4);
    end
    if (dropResp) begin
      drop_d = drop_q - CW'(1);
    end
    if (redirect) begin
      qCount_d  = '0;
      fetchPc_d = {redirect_pc[XLEN-1:2], 2'b00};
      drop_d    = outstanding_d;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetchPc_q     <= RESET_VECTOR;
      qCount_q      <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetchPc_q     <= fetchPc_d;
      qCount_q      <= qCount_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // Instruction queue: write at tail on accepted responses, read at head on pops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      qHead_q <= '0;
      qTail_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        qInstr_q[i] <= '0;
        qPc_q[i]    <= '0;
      end
    end else begin
      if (push) begin
        qInstr_q[qTail_q] <= imem_rdata;
        qPc_q[qTail_q]    <= respPc;
        qTail_q           <= qTail_q + PW'(1);
      end
      if (redirect) begin
        qHead_q <= qTail_q;
      end else if (pop) begin
        qHead_q <= qHead_q + PW'(1);
      end
    end
  end

  // PC FIFO pointers follow issue and response order, including responses that are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pfHead_q <= '0;
      pfTail_q <= '0;
    end else begin
      if (issue) begin
        pfTail_q <= pfTail_q + PW'(1);
      end
      if (resp) begin
        pfHead_q <= pfHead_q + PW'(1);
      end
    end
  end

  // PC FIFO storage records the address of each issued request.
  always_ff @(posedge clk) begin
    if (issue) begin
      pcFifo_q[pfTail_q] <= fetchPc_q;
    end
  end

endmodule
